// File: rtl/trigger_sequencer_if.sv
// rtl/trigger_sequencer_if.sv - trigger/count handshake bundle between sequencer and counter side
interface trigger_sequencer_if #(
    parameter int CNT_W = 4
);
    logic             start;
    logic [CNT_W-1:0] burst_len;
    logic [CNT_W-1:0] cnt_in;
    logic             trigger;
    logic             busy;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] fired_cnt;

    modport master (
        input  start, burst_len, cnt_in,
        output trigger, busy, done, err, fired_cnt
    );

    modport slave (
        output start, burst_len, cnt_in,
        input  trigger, busy, done, err, fired_cnt
    );
endinterface

// File: rtl/trigger_sequencer.sv
// rtl/trigger_sequencer.sv - fires bursts of trigger pulses and tracks the downstream counter
module trigger_sequencer #(
    parameter int CNT_W      = 4,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    trigger_sequencer_if.master  bus
);
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FIRE, S_WAIT_START, S_WAIT_DONE, S_GAP, S_FINISH
    } state_t;

    state_t           state, state_d;
    logic [TO_W-1:0]  tcnt;
    logic [GAP_W-1:0] gcnt;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] fired_q;
    logic             err_q;
    logic             timeout_hit;
    logic             timeout_err;
    logic             gap_last;

    assign timeout_hit = (tcnt == TO_W'(TIMEOUT - 1));
    assign gap_last    = (gcnt == GAP_W'(GAP_CYCLES - 1));
    // A timeout only counts while the counter is still in the state being waited on.
    assign timeout_err = timeout_hit &&
                         (((state == S_WAIT_START) && (bus.cnt_in == '0)) ||
                          ((state == S_WAIT_DONE)  && (bus.cnt_in != '0)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: begin
                if (bus.start) state_d = (bus.burst_len == '0) ? S_FINISH : S_FIRE;
            end
            S_FIRE:       state_d = S_WAIT_START;
            S_WAIT_START: begin
                if (bus.cnt_in != '0) state_d = S_WAIT_DONE;
                else if (timeout_hit) state_d = S_FINISH;
            end
            S_WAIT_DONE: begin
                if (bus.cnt_in == '0) state_d = (fired_q < len_q) ? S_GAP : S_FINISH;
                else if (timeout_hit) state_d = S_FINISH;
            end
            S_GAP: begin
                if (gap_last) state_d = S_FIRE;
            end
            S_FINISH:     state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.trigger   = (state == S_FIRE);
        bus.busy      = (state != S_IDLE);
        bus.done      = (state == S_FINISH);
        bus.err       = err_q;
        bus.fired_cnt = fired_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt    <= '0;
            gcnt    <= '0;
            len_q   <= '0;
            fired_q <= '0;
            err_q   <= 1'b0;
        end else begin
            // Saturating residency counter, restarted on every state change.
            if (state_d != state)              tcnt <= '0;
            else if (tcnt != TO_W'(TIMEOUT))   tcnt <= tcnt + TO_W'(1);

            if ((state == S_GAP) && (state_d == S_GAP)) gcnt <= gcnt + GAP_W'(1);
            else                                        gcnt <= '0;

            if ((state == S_IDLE) && bus.start) begin
                len_q   <= bus.burst_len;
                fired_q <= '0;
                err_q   <= 1'b0;
            end

            if ((state == S_FIRE) && (fired_q != len_q)) fired_q <= fired_q + CNT_W'(1);

            if (timeout_err) err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_trigger_sequencer.sv
// tb/tb_trigger_sequencer.sv - randomized self-checking bench with behavioural counter and timing model
module tb_trigger_sequencer;
    localparam int CNT_W = 4;
    localparam int GAP   = 2;
    localparam int TO    = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    trigger_sequencer_if #(.CNT_W(CNT_W)) bus ();

    trigger_sequencer #(
        .CNT_W(CNT_W), .GAP_CYCLES(GAP), .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int trig_q[$];
    int done_q[$];

    logic             model_en = 1'b1;
    int               model_n = 4;
    logic [CNT_W-1:0] cnt = '0;

    assign bus.cnt_in = cnt;

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream counter: after a trigger it steps 1..N, then back to 0.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                cnt <= '0;
        else if (!model_en)        cnt <= '0;
        else if (bus.trigger)      cnt <= CNT_W'(1);
        else if (cnt != '0)        cnt <= (int'(cnt) == model_n) ? '0 : cnt + CNT_W'(1);
    end

    always @(negedge clk) begin
        if (bus.trigger) trig_q.push_back(cyc);
        if (bus.done)    done_q.push_back(cyc);
    end

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.burst_len = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++; if (bus.trigger !== 1'b0) begin fails++; $display("FAIL reset_trigger: got %b expected 0", bus.trigger); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        tests++; if (bus.err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected 0", bus.err); end
        tests++; if (bus.fired_cnt !== '0) begin fails++; $display("FAIL reset_fired: got %0d expected 0", bus.fired_cnt); end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests++;
            if ({bus.trigger, bus.busy, bus.done, bus.err} !== 4'b0) begin
                fails++;
                $display("FAIL post_reset_idle: got t/b/d/e=%b expected 0000", {bus.trigger, bus.busy, bus.done, bus.err});
            end
        end
    endtask

    // Runs one burst and compares trigger/done timing against the arithmetic model.
    // ign >= 0 pulses start (with a different burst_len) ign cycles after acceptance.
    task automatic do_burst(input int len, input int n, input int ign, input string tag);
        int  s, t, exp_done;
        int  exp_t[$];
        bit  got;
        model_en = 1'b1;
        model_n = n;
        trig_q.delete();
        done_q.delete();
        @(negedge clk);
        bus.burst_len = CNT_W'(len);
        bus.start = 1'b1;
        @(posedge clk); #1;
        s = cyc;
        bus.start = 1'b0;
        bus.burst_len = CNT_W'($urandom_range(0, 15));
        t = s;
        for (int i = 0; i < len; i++) begin
            exp_t.push_back(t);
            t += n + 2 + GAP;
        end
        exp_done = (len == 0) ? s : exp_t[len-1] + n + 2;
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk); #1;
            bus.start = (ign >= 0 && cyc == s + ign);
            if (bus.start) bus.burst_len = CNT_W'(len + 3);
            if (done_q.size() != 0) got = 1'b1;
        end
        bus.start = 1'b0;
        tests++;
        if (!got) begin fails++; $display("FAIL %s_done_seen: got none expected cycle %0d", tag, exp_done - s); end
        tests++;
        if (done_q.size() != 0 && done_q[0] != exp_done) begin
            fails++; $display("FAIL %s_done_cycle: got %0d expected %0d", tag, done_q[0] - s, exp_done - s);
        end
        tests++;
        if (bus.fired_cnt !== CNT_W'(len)) begin fails++; $display("FAIL %s_fired: got %0d expected %0d", tag, bus.fired_cnt, len); end
        tests++;
        if (bus.err !== 1'b0) begin fails++; $display("FAIL %s_err: got %b expected 0", tag, bus.err); end
        @(negedge clk);
        tests++;
        if (bus.busy !== 1'b0) begin fails++; $display("FAIL %s_busy_after_done: got %b expected 0", tag, bus.busy); end
        tests++;
        if (done_q.size() != 1) begin fails++; $display("FAIL %s_done_count: got %0d expected 1", tag, done_q.size()); end
        tests++;
        if (trig_q.size() != exp_t.size()) begin
            fails++; $display("FAIL %s_trig_count: got %0d expected %0d", tag, trig_q.size(), exp_t.size());
        end
        for (int i = 0; i < exp_t.size() && i < trig_q.size(); i++) begin
            tests++;
            if (trig_q[i] != exp_t[i]) begin
                fails++; $display("FAIL %s_trig%0d_cycle: got %0d expected %0d", tag, i, trig_q[i] - s, exp_t[i] - s);
            end
        end
    endtask

    task automatic test_single();  do_burst(1, 5, -1, "single"); endtask
    task automatic test_burst();   do_burst(3, 4, -1, "burst");  endtask
    task automatic test_zero();    do_burst(0, 3, -1, "zero");   endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++)
            do_burst($urandom_range(1, 4), $urandom_range(1, 10), -1, "random");
    endtask

    task automatic test_timeout();
        int s;
        bit got;
        model_en = 1'b0;
        trig_q.delete();
        done_q.delete();
        @(negedge clk);
        bus.burst_len = CNT_W'(2);
        bus.start = 1'b1;
        @(posedge clk); #1;
        s = cyc;
        bus.start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < TO + 20 && !got; i++) begin
            @(negedge clk); #1;
            if (done_q.size() != 0) got = 1'b1;
        end
        tests++;
        if (!got || done_q[0] != s + TO + 1) begin
            fails++; $display("FAIL timeout_done_cycle: got %0d expected %0d", got ? done_q[0] - s : -1, TO + 1);
        end
        tests++;
        if (bus.err !== 1'b1) begin fails++; $display("FAIL timeout_err_with_done: got %b expected 1", bus.err); end
        tests++;
        if (trig_q.size() != 1 || trig_q[0] != s) begin
            fails++; $display("FAIL timeout_triggers: got count %0d expected 1 at offset 0", trig_q.size());
        end
        tests++;
        if (bus.fired_cnt !== CNT_W'(1)) begin fails++; $display("FAIL timeout_fired: got %0d expected 1", bus.fired_cnt); end
        @(negedge clk);
        tests++;
        if (bus.err !== 1'b1) begin fails++; $display("FAIL timeout_err_sticky: got %b expected 1", bus.err); end
        model_en = 1'b1;
        model_n = 3;
        bus.burst_len = CNT_W'(1);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        tests++;
        if (bus.err !== 1'b0) begin fails++; $display("FAIL timeout_err_cleared: got %b expected 0", bus.err); end
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk); #1;
            if (!bus.busy) got = 1'b1;
        end
        tests++;
        if (!got) begin fails++; $display("FAIL timeout_recover_idle: got busy expected idle"); end
    endtask

    task automatic test_back_to_back();
        int  s, d, exp_t[$], exp_d2;
        bit  got;
        model_en = 1'b1;
        model_n = 2;
        trig_q.delete();
        done_q.delete();
        @(negedge clk);
        bus.burst_len = CNT_W'(2);
        bus.start = 1'b1;
        @(posedge clk); #1;
        s = cyc;
        bus.burst_len = CNT_W'(1);
        d = s + 2 * (model_n + 2) + GAP;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk); #1;
            if (done_q.size() != 0) got = 1'b1;
        end
        @(posedge clk);
        @(posedge clk); #1;
        bus.start = 1'b0;
        exp_t = '{s, s + model_n + 2 + GAP, d + 2};
        exp_d2 = d + 2 + model_n + 2;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk); #1;
            if (done_q.size() > 1) got = 1'b1;
        end
        tests++;
        if (done_q.size() != 2 || done_q[0] != d || done_q[1] != exp_d2) begin
            fails++; $display("FAIL b2b_done: got count %0d expected dones at %0d,%0d", done_q.size(), d - s, exp_d2 - s);
        end
        tests++;
        if (trig_q != exp_t) begin
            fails++; $display("FAIL b2b_triggers: got count %0d expected 3 at offsets 0,%0d,%0d", trig_q.size(), exp_t[1] - s, exp_t[2] - s);
        end
        tests++;
        if (bus.fired_cnt !== CNT_W'(1)) begin fails++; $display("FAIL b2b_fired: got %0d expected 1", bus.fired_cnt); end
    endtask

    task automatic test_abort();
        int s, ndone;
        do_burst(2, 8, 4, "ignore");
        model_n = 8;
        trig_q.delete();
        done_q.delete();
        @(negedge clk);
        bus.burst_len = CNT_W'(3);
        bus.start = 1'b1;
        @(posedge clk); #1;
        s = cyc;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        tests++; if (bus.trigger !== 1'b0) begin fails++; $display("FAIL abort_trigger: got %b expected 0", bus.trigger); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
        tests++; if (bus.fired_cnt !== '0) begin fails++; $display("FAIL abort_fired: got %0d expected 0", bus.fired_cnt); end
        ndone = done_q.size();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (done_q.size() != 0 || ndone != 0) begin fails++; $display("FAIL abort_no_done: got %0d expected 0", done_q.size()); end
        tests++;
        if (trig_q.size() != 1 || trig_q[0] != s) begin fails++; $display("FAIL abort_triggers: got %0d expected 1", trig_q.size()); end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.burst_len = '0;
        test_reset();
        test_single();
        test_burst();
        test_zero();
        test_random();
        test_timeout();
        test_back_to_back();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
